shift_add_mult_4: RTL

Sequential 4x4 unsigned multiplier controller. It time-shares a single `ripple_adder_4` instance over four add/shift iterations to produce an 8-bit product. It sits alongside the combinational array and tree multipliers as the minimum-area reference point, and serves as the sequencing template for wider shift-add variants. The accumulate step is computed entirely by the existing `ripple_adder_4`; this block owns the registers, the iteration counter and the handshake.

---
 rtl/mult_pkg.sv | 19 +
 rtl/ripple_adder_4.sv | 29 ++
 rtl/shift_add_mult_4.sv | 97 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mult_pkg
// Purpose  : Shared types and sizing for the sequential shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH = 4;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/ripple_adder_4.sv
`default_nettype none
// ============================================================================
// Module   : ripple_adder_4
// Purpose  : 4-bit combinational ripple-carry adder.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_adder_4 (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign sum[i]   = in1[i] ^ in2[i] ^ w_c[i];
            assign w_c[i+1] = (in1[i] & in2[i]) | (w_c[i] & (in1[i] ^ in2[i]));
        end
    endgenerate

    assign cout = w_c[4];

endmodule : ripple_adder_4
`default_nettype wire

// File: rtl/shift_add_mult_4.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_4
// Purpose  : Sequential 4x4 unsigned multiplier, one add/shift per cycle
//            through a single shared ripple_adder_4.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_4
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_q_next;

    // Q[0] selects the addend; the adder itself is never idled.
    assign w_addend = r_q[0] ? r_m : '0;

    ripple_adder_4 u_add (
        .in1  (r_a),
        .in2  (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // {cout,sum,Q} >> 1: the carry shifts straight into A[3], so the
    // post-shift carry bit is always zero and needs no flop of its own.
    assign w_a_next = {w_cout, w_sum[WIDTH-1:1]};
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    assign ready   = (r_state == IDLE);
    assign busy    = ~ready;
    assign done    = r_done;
    assign product = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= in1;
                        r_q     <= in2;
                        r_a     <= '0;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a <= w_a_next;
                    r_q <= w_q_next;
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        r_product <= {w_a_next, w_q_next};
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : shift_add_mult_4
`default_nettype wire
